mac_array_param: RTL and testbench

- Parametrised N_OUT-wide multiply-accumulate array for fully connected layers; successor to the fixed 10-lane layer-2 array.
- One shared activation is streamed per valid beat against N_OUT weights.
- Adds a two-stage pipeline, a start/last sequencing FSM, saturating accumulation with sticky overflow flags, and requantised 8-bit outputs with optional ReLU.
- Sits between the weight/activation memories and the next layer or argmax stage.

---
 rtl/mac_array_param.sv | 150 +++++++++++++++
 tb/tb_mac_array_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_param.sv
// Parametrised N_OUT-lane multiply-accumulate array for fully connected layers.
// One activation per beat against N_OUT weights, two-stage pipeline, saturating accumulators.
module mac_array_param #(
  parameter int N_OUT      = 10,
  parameter int DW         = 8,
  parameter int ACC_W      = 20,
  parameter int BIAS_SHIFT = 0,
  parameter int OUT_SHIFT  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic signed [DW-1:0]      activation,
  input  logic [N_OUT*DW-1:0]       weights_packed,
  input  logic [N_OUT*DW-1:0]       biases_packed,
  input  logic                      relu_en,
  output logic                      busy,
  output logic                      out_valid,
  output logic [N_OUT*ACC_W-1:0]    acc_out_packed,
  output logic [N_OUT*DW-1:0]       q_out_packed,
  output logic [N_OUT-1:0]          sat_packed
);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  localparam logic signed [ACC_W:0]   ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] Q_MAX   = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Q_MIN   = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_t                  state;
  logic                    p_valid;
  logic [N_OUT-1:0]        sat;
  logic signed [ACC_W-1:0] acc     [N_OUT];
  logic signed [2*DW-1:0]  prod    [N_OUT];
  logic signed [2*DW-1:0]  mult    [N_OUT];
  logic signed [ACC_W-1:0] bias_ld [N_OUT];
  logic signed [ACC_W:0]   sum     [N_OUT];
  logic signed [ACC_W-1:0] acc_nxt [N_OUT];
  logic [N_OUT-1:0]        ovf;
  logic signed [ACC_W-1:0] t       [N_OUT];

  // Per-lane datapath: product, bias load value and saturating sum.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ovf = '0;
    for (int i = 0; i < N_OUT; i++) begin
      logic [2*DW-1:0] a_ext;
      logic [2*DW-1:0] w_ext;
      logic [ACC_W-1:0] b_ext;
      a_ext      = {{DW{activation[DW-1]}}, activation};
      w_ext      = {{DW{weights_packed[i*DW+DW-1]}}, weights_packed[i*DW +: DW]};
      mult[i]    = a_ext * w_ext;
      b_ext      = {{(ACC_W-DW){biases_packed[i*DW+DW-1]}}, biases_packed[i*DW +: DW]};
      bias_ld[i] = b_ext <<< BIAS_SHIFT;
      sum[i]     = {acc[i][ACC_W-1], acc[i]}
                 + {{(ACC_W+1-2*DW){prod[i][2*DW-1]}}, prod[i]};
      acc_nxt[i] = sum[i][ACC_W-1:0];
      if (sum[i] > ACC_MAX) begin
        acc_nxt[i] = ACC_MAX[ACC_W-1:0];
        ovf[i]     = 1'b1;
      end else if (sum[i] < ACC_MIN) begin
        acc_nxt[i] = ACC_MIN[ACC_W-1:0];
        ovf[i]     = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      p_valid   <= 1'b0;
      sat       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      // NOTE: the accumulators are flops, not a RAM, so they are reset lane by lane.
      for (int i = 0; i < N_OUT; i++) begin
        acc[i]  <= '0;
        prod[i] <= '0;
      end
    end else if (clr) begin
      state     <= IDLE;
      p_valid   <= 1'b0;
      sat       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < N_OUT; i++) acc[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          p_valid <= 1'b0;
          if (start) begin
            state <= ACC;
            busy  <= 1'b1;
            sat   <= '0;
            for (int i = 0; i < N_OUT; i++) acc[i] <= bias_ld[i];
          end
        end
        ACC: begin
          p_valid <= in_valid;
          if (in_valid) begin
            for (int i = 0; i < N_OUT; i++) prod[i] <= mult[i];
            if (in_last) state <= DRAIN;
          end
          if (p_valid) begin
            for (int i = 0; i < N_OUT; i++) acc[i] <= acc_nxt[i];
            sat <= sat | ovf;
          end
        end
        DRAIN: begin
          // The final beat's product is still in flight; fold it in here.
          p_valid   <= 1'b0;
          state     <= DONE;
          out_valid <= 1'b1;
          if (p_valid) begin
            for (int i = 0; i < N_OUT; i++) acc[i] <= acc_nxt[i];
            sat <= sat | ovf;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Requantisation: arithmetic shift, optional ReLU, clamp to DW bits.
  always_comb begin
    acc_out_packed = '0;
    q_out_packed   = '0;
    for (int i = 0; i < N_OUT; i++) begin
      acc_out_packed[i*ACC_W +: ACC_W] = acc[i];
      t[i] = acc[i] >>> OUT_SHIFT;
      if (relu_en && t[i][ACC_W-1]) t[i] = '0;
      if (t[i] > Q_MAX)      q_out_packed[i*DW +: DW] = Q_MAX[DW-1:0];
      else if (t[i] < Q_MIN) q_out_packed[i*DW +: DW] = Q_MIN[DW-1:0];
      else                   q_out_packed[i*DW +: DW] = t[i][DW-1:0];
    end
  end

  assign sat_packed = sat;

endmodule

// File: tb/tb_mac_array_param.sv
// Directed self-checking bench for mac_array_param (OUT_SHIFT=2 instance).
// Covers bias load, saturation, ReLU, gaps/ignored inputs, clr and async reset.
module tb_mac_array_param;

  localparam int N_OUT     = 10;
  localparam int DW        = 8;
  localparam int ACC_W     = 20;
  localparam int OUT_SHIFT = 2;

  localparam int E5_ACC [N_OUT] = '{-38, -31, -24, -17, -10, -3, 4, 11, 18, 25};
  localparam int E5_Q   [N_OUT] = '{-10, -8, -6, -5, -3, -1, 1, 2, 4, 6};

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   clr;
  logic                   start;
  logic                   in_valid;
  logic                   in_last;
  logic signed [DW-1:0]   activation;
  logic [N_OUT*DW-1:0]    weights_packed;
  logic [N_OUT*DW-1:0]    biases_packed;
  logic                   relu_en;
  logic                   busy;
  logic                   out_valid;
  logic [N_OUT*ACC_W-1:0] acc_out_packed;
  logic [N_OUT*DW-1:0]    q_out_packed;
  logic [N_OUT-1:0]       sat_packed;

  mac_array_param #(
    .N_OUT(N_OUT), .DW(DW), .ACC_W(ACC_W), .BIAS_SHIFT(0), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start),
    .in_valid(in_valid), .in_last(in_last), .activation(activation),
    .weights_packed(weights_packed), .biases_packed(biases_packed),
    .relu_en(relu_en), .busy(busy), .out_valid(out_valid),
    .acc_out_packed(acc_out_packed), .q_out_packed(q_out_packed),
    .sat_packed(sat_packed)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int passed   = 0;
  int ov_count = 0;

  always @(posedge clk) if (out_valid === 1'b1) ov_count++;

  logic [N_OUT*ACC_W-1:0] exp_acc;
  logic [N_OUT*DW-1:0]    exp_q;

  task automatic check(input string tag, input logic [N_OUT*ACC_W-1:0] obs,
                       input logic [N_OUT*ACC_W-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic signed [DW-1:0] act, input logic last);
    in_valid   = 1'b1;
    in_last    = last;
    activation = act;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    activation = '0; weights_packed = '0; biases_packed = '0; relu_en = 1'b0;

    // Reset state
    #3;
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_acc", acc_out_packed, 0);
    check("rst_sat", sat_packed, 0);
    check("rst_q", q_out_packed, 0);
    tick();
    rst = 1'b0;
    tick();

    // Test 1: bias i, 32 beats of act=1, w=2 -> acc=i+64
    for (int i = 0; i < N_OUT; i++) begin
      biases_packed[i*DW +: DW]  = DW'(i);
      weights_packed[i*DW +: DW] = 8'sd2;
    end
    ov_count = 0;
    do_start();
    check("t1_busy_after_start", busy, 1);
    check("t1_bias_load", acc_out_packed[ACC_W-1:0], 0);
    for (int b = 1; b <= 32; b++) beat(8'sd1, b == 32);
    check("t1_ov_in_drain", out_valid, 0);
    tick();
    check("t1_ov_pulse", out_valid, 1);
    for (int i = 0; i < N_OUT; i++) begin
      exp_acc[i*ACC_W +: ACC_W] = ACC_W'(i + 64);
      exp_q[i*DW +: DW]         = DW'((i + 64) / 4);
    end
    check("t1_acc", acc_out_packed, exp_acc);
    check("t1_q", q_out_packed, exp_q);
    check("t1_sat", sat_packed, 0);
    tick();
    check("t1_ov_drop", out_valid, 0);
    check("t1_busy_drop", busy, 0);
    tick(); tick();
    check("t1_hold_acc", acc_out_packed, exp_acc);
    check("t1_ov_count", ov_count, 1);

    // Test 2: saturation both ways; even lanes +16384/beat, odd lanes -16256/beat
    biases_packed = '0;
    for (int i = 0; i < N_OUT; i++)
      weights_packed[i*DW +: DW] = (i % 2 == 0) ? 8'h80 : 8'h7F;
    do_start();
    for (int b = 1; b <= 40; b++) beat(-8'sd128, b == 40);
    tick();
    check("t2_ov_pulse", out_valid, 1);
    for (int i = 0; i < N_OUT; i++) begin
      exp_acc[i*ACC_W +: ACC_W] = (i % 2 == 0) ? 20'h7FFFF : 20'h80000;
      exp_q[i*DW +: DW]         = (i % 2 == 0) ? 8'h7F : 8'h80;
    end
    check("t2_acc_clamp", acc_out_packed, exp_acc);
    check("t2_q_clamp", q_out_packed, exp_q);
    check("t2_sat_all", sat_packed, 10'h3FF);

    // Test 3: ReLU, single beat act=5, w0=-3, w1=3 -> acc -15/15
    tick();
    weights_packed = '0;
    weights_packed[0 +: DW]  = 8'hFD;
    weights_packed[DW +: DW] = 8'h03;
    do_start();
    check("t3_sat_cleared", sat_packed, 0);
    beat(8'sd5, 1'b1);
    check("t3_ov_in_drain", out_valid, 0);
    tick();
    check("t3_ov_pulse", out_valid, 1);
    exp_acc = '0;
    exp_acc[0 +: ACC_W]     = 20'hFFFF1;
    exp_acc[ACC_W +: ACC_W] = 20'h0000F;
    check("t3_acc", acc_out_packed, exp_acc);
    relu_en = 1'b1;
    #1;
    exp_q = '0;
    exp_q[DW +: DW] = 8'd3;
    check("t3_q_relu_on", q_out_packed, exp_q);
    relu_en = 1'b0;
    #1;
    exp_q[0 +: DW] = 8'hFC;
    check("t3_q_relu_off", q_out_packed, exp_q);

    // Test 4: gaps plus ignored start / in_valid -> same as test 1
    tick();
    for (int i = 0; i < N_OUT; i++) begin
      biases_packed[i*DW +: DW]  = DW'(i);
      weights_packed[i*DW +: DW] = 8'sd2;
    end
    in_valid = 1'b1; in_last = 1'b1; activation = 8'sd100;
    tick();
    check("t4_idle_beat_ignored", busy, 0);
    in_last = 1'b0;
    ov_count = 0;
    do_start();
    in_valid = 1'b0;
    for (int b = 1; b <= 32; b++) begin
      beat(8'sd1, b == 32);
      if (b == 10) begin
        for (int i = 0; i < N_OUT; i++) biases_packed[i*DW +: DW] = 8'sd50;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_busy_mid_acc", busy, 1);
      end
      if (b < 32) repeat (b % 4) tick();
    end
    in_valid = 1'b1; in_last = 1'b1; activation = 8'sd100;
    tick();
    check("t4_ov_pulse", out_valid, 1);
    for (int i = 0; i < N_OUT; i++) begin
      exp_acc[i*ACC_W +: ACC_W] = ACC_W'(i + 64);
      exp_q[i*DW +: DW]         = DW'((i + 64) / 4);
    end
    check("t4_acc", acc_out_packed, exp_acc);
    check("t4_q", q_out_packed, exp_q);
    tick();
    check("t4_ov_drop", out_valid, 0);
    tick();
    check("t4_idle_hold_acc", acc_out_packed, exp_acc);
    check("t4_idle_busy", busy, 0);
    in_valid = 1'b0; in_last = 1'b0;
    check("t4_ov_count", ov_count, 1);

    // Test 5a: clr mid-ACC
    biases_packed = '0;
    for (int i = 0; i < N_OUT; i++) weights_packed[i*DW +: DW] = 8'sd1;
    do_start();
    for (int b = 1; b <= 3; b++) beat(8'sd10, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t5_clr_busy", busy, 0);
    check("t5_clr_acc", acc_out_packed, 0);
    tick(); tick();
    check("t5_clr_no_ov", out_valid, 0);

    // Test 5b: async reset in DRAIN
    ov_count = 0;
    do_start();
    beat(8'sd10, 1'b0);
    beat(8'sd10, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_acc_async", acc_out_packed, 0);
    check("t5_rst_busy_async", busy, 0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("t5_rst_no_ov", ov_count, 0);

    // Test 5c: fresh single-beat sequence, bias -3, w[i]=i-5, act=7
    for (int i = 0; i < N_OUT; i++) begin
      biases_packed[i*DW +: DW]  = 8'hFD;
      weights_packed[i*DW +: DW] = DW'(i - 5);
    end
    do_start();
    beat(8'sd7, 1'b1);
    check("t5_fresh_ov_in_drain", out_valid, 0);
    tick();
    check("t5_fresh_ov_pulse", out_valid, 1);
    for (int i = 0; i < N_OUT; i++) begin
      exp_acc[i*ACC_W +: ACC_W] = ACC_W'(E5_ACC[i]);
      exp_q[i*DW +: DW]         = DW'(E5_Q[i]);
    end
    check("t5_fresh_acc", acc_out_packed, exp_acc);
    check("t5_fresh_q", q_out_packed, exp_q);
    check("t5_fresh_sat", sat_packed, 0);
    tick();
    check("t5_fresh_ov_count", ov_count, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
